// File: rtl/fetch_queue.sv
// Instruction fetch queue: a single-outstanding fetch FSM feeding a DEPTH-entry FIFO towards decode.
// Define FETCH_QUEUE_BYPASS_EN to forward returning data straight to decode when the FIFO is empty.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     startin,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     id_ready,
  output logic                     id_valid,
  output logic [31:0]              id_instr,
  output logic [31:0]              id_pc_plus_4,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int              PW   = $clog2(DEPTH);
  localparam int              CW   = PW + 1;
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc4_q   [DEPTH];

  logic          ack_take_s;
  logic          bypass_s;
  logic          push_s;
  logic          pop_s;
  logic [31:0]   pc_plus_4_s;
  logic [31:0]   redirect_target_s;

  assign pc_plus_4_s       = fetch_pc_q + 32'd4;
  assign redirect_target_s = redirect_pc & 32'hFFFF_FFFC;
  assign ack_take_s        = (state_q == REQ) && imem_ack && !redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
  // Data returning into an empty queue is presented to decode in the same cycle.
  assign bypass_s = ack_take_s && (count_q == {CW{1'b0}});
`else
  assign bypass_s = 1'b0;
`endif

  assign push_s = ack_take_s && !(bypass_s && id_ready);
  assign pop_s  = (count_q != {CW{1'b0}}) && id_ready && !redirect;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      rd_ptr_d = {PW{1'b0}};
      wr_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Next state; count_d is the post-update occupancy that decides whether another slot can be reserved.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_target_s;
        end else if (count_q < FULL) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (redirect) begin
          fetch_pc_d = redirect_target_s;
          state_d    = imem_ack ? IDLE : DROP;
        end else if (imem_ack) begin
          fetch_pc_d = pc_plus_4_s;
          state_d    = (count_d < FULL) ? REQ : IDLE;
        end else begin
          state_d = REQ;
        end
      end
      DROP: begin
        if (redirect) begin
          fetch_pc_d = redirect_target_s;
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
        if (imem_ack) begin
          state_d = IDLE;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (startin) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= {PW{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_s && !startin) begin
      instr_q[wr_ptr_q] <= imem_rdata;
      pc4_q[wr_ptr_q]   <= pc_plus_4_s;
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = 32'h0000_0000;
    if (!startin && (state_q == REQ)) begin
      imem_req  = 1'b1;
      imem_addr = fetch_pc_q;
    end else begin
      imem_req  = 1'b0;
    end
  end

  // Decode-side view is forced to zero while reset is asserted.
  always_comb begin
    id_valid     = 1'b0;
    id_instr     = 32'h0000_0000;
    id_pc_plus_4 = 32'h0000_0000;
    occupancy    = {CW{1'b0}};
    if (startin) begin
      id_valid = 1'b0;
    end else begin
      occupancy = count_q;
      if (count_q != {CW{1'b0}}) begin
        id_valid     = 1'b1;
        id_instr     = instr_q[rd_ptr_q];
        id_pc_plus_4 = pc4_q[rd_ptr_q];
      end else if (bypass_s) begin
        id_valid     = 1'b1;
        id_instr     = imem_rdata;
        id_pc_plus_4 = pc_plus_4_s;
      end else begin
        id_valid = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a queue-based reference model of fetched words, a reactive
// memory model, directed scenarios followed by randomized traffic.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        startin = 1'b0, imem_ack = 1'b0, redirect = 1'b0, id_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0, redirect_pc = 32'h0;
  logic        imem_req, id_valid;
  logic [31:0] imem_addr, id_instr, id_pc_plus_4;
  logic [2:0]  occupancy;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .startin(startin), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .id_ready(id_ready), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc_plus_4(id_pc_plus_4), .occupancy(occupancy)
  );

  int checks = 0, errors = 0;
  logic [31:0] q_instr[$], q_pc4[$];
  logic [31:0] exp_pc = 32'h0;
  bit owed = 1'b0, stale = 1'b0;
  int p_ack = 100, p_ready = 100, p_redir = 0, p_rst = 0, p_spur = 0, p_owed = 50;
  bit f_rst = 1'b0, f_redir = 1'b0;
  logic [31:0] f_redir_pc = 32'h0;
  logic s_rst = 1'b0, s_redir = 1'b0, s_ack = 1'b0, s_req = 1'b0, s_ready = 1'b0;
  logic [31:0] s_rpc = 32'h0, s_rdata = 32'h0;
  int idle_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit roll(input int pct);
    return int'($urandom_range(99, 0)) < pct;
  endfunction

  // One clock of stimulus: drive at negedge, answer memory, snapshot, then advance the model at posedge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      startin     = f_rst || (int'($urandom_range(999, 0)) < p_rst);
      redirect    = !startin && (f_redir || roll(p_redir));
      redirect_pc = f_redir ? f_redir_pc : $urandom();
      id_ready    = roll(p_ready);
      f_rst       = 1'b0;
      f_redir     = 1'b0;
      #1;
      imem_ack   = 1'b0;
      imem_rdata = $urandom();
      if (startin) begin
        imem_ack = 1'b0;
      end else if (stale) begin
        imem_ack = !imem_req;
        stale    = 1'b0;
      end else if (owed) begin
        imem_ack = roll(p_owed);
      end else if (imem_req) begin
        imem_ack   = roll(p_ack);
        imem_rdata = mem_word(imem_addr);
      end else begin
        imem_ack = roll(p_spur);
      end
      #1;
      s_rst = startin; s_redir = redirect; s_ack = imem_ack; s_req = imem_req;
      s_ready = id_ready; s_rpc = redirect_pc; s_rdata = imem_rdata;
      if (s_req) begin
        check("imem_addr", imem_addr, exp_pc);
        check("req_room", 32'(q_instr.size() < DEPTH), 32'd1);
      end
      if (!s_rst && !s_redir && !s_req && !owed && (q_instr.size() < DEPTH)) idle_cnt++;
      else idle_cnt = 0;
      if (idle_cnt > 2) begin
        check("fetch_stall", 32'(idle_cnt), 32'd2);
        idle_cnt = 0;
      end
      @(posedge clk);
      if (s_rst) begin
        q_instr.delete(); q_pc4.delete();
        exp_pc = RESET_PC;
        stale  = stale || s_req || owed;
        owed   = 1'b0;
      end else if (s_redir) begin
        q_instr.delete(); q_pc4.delete();
        exp_pc = s_rpc & 32'hFFFF_FFFC;
        if (s_req && !s_ack) owed = 1'b1;
        else if (owed && s_ack) owed = 1'b0;
      end else if (s_req && s_ack) begin
        q_instr.push_back(s_rdata);
        q_pc4.push_back(exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
      end else if (owed && s_ack) begin
        owed = 1'b0;
      end
    end
  endtask

  // Monitor: compares the decode-side view against the scoreboard head and retires consumed entries.
  always begin
    @(negedge clk);
    #3;
    if (s_rst) begin
      check("rst_valid", 32'(id_valid), 32'd0);
      check("rst_instr", id_instr, 32'd0);
      check("rst_pc4", id_pc_plus_4, 32'd0);
      check("rst_occ", 32'(occupancy), 32'd0);
      check("rst_req", 32'(imem_req), 32'd0);
    end else begin
      check("occupancy", 32'(occupancy), 32'(q_instr.size()));
      check("id_valid", 32'(id_valid), 32'(q_instr.size() != 0));
      if (q_instr.size() != 0) begin
        check("id_instr", id_instr, q_instr[0]);
        check("id_pc_plus_4", id_pc_plus_4, q_pc4[0]);
        if (s_ready && !s_redir) begin
          void'(q_instr.pop_front());
          void'(q_pc4.pop_front());
        end
      end else begin
        check("idle_instr", id_instr, 32'd0);
        check("idle_pc4", id_pc_plus_4, 32'd0);
      end
    end
  end

  initial begin
    bit reached;
    f_rst = 1'b1; run(1);
    // Streaming fetch with immediate acks and an always-ready decoder.
    p_ack = 100; p_ready = 100; run(12);
    // Stall decode until the queue fills.
    p_ready = 0; run(15); #2;
    check("full_occ", 32'(occupancy), 32'd4);
    check("full_noreq", 32'(imem_req), 32'd0);
    p_ready = 100; run(1); #2;
    check("pop_occ", 32'(occupancy), 32'd3);
    p_ready = 0; run(1); #2;
    check("rereq", 32'(imem_req), 32'd1);
    // Redirect with an outstanding request; its late ack must be dropped.
    f_rst = 1'b1; run(1);
    p_ack = 0; p_owed = 0; run(4);
    f_redir = 1'b1; f_redir_pc = 32'h0000_0103; run(1); #2;
    check("redir_occ", 32'(occupancy), 32'd0);
    run(2);
    p_owed = 100; run(1);
    p_owed = 50; run(1); #2;
    check("redir_req", 32'(imem_req), 32'd1);
    check("redir_addr", imem_addr, 32'h0000_0100);
    // Redirect coinciding with an ack.
    p_ack = 100; f_redir = 1'b1; f_redir_pc = 32'h0000_0200; run(1);
    p_ack = 0; run(1); #2;
    check("redir_ack_addr", imem_addr, 32'h0000_0200);
    check("redir_ack_valid", 32'(id_valid), 32'd0);
    // Reset with three entries queued and a request in flight.
    f_rst = 1'b1; run(1);
    p_ack = 100; p_ready = 0; reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      run(1); #2;
      reached = (occupancy == 3'd3);
    end
    check("fill3", 32'(occupancy), 32'd3);
    p_ack = 0; run(1);
    f_rst = 1'b1; run(1);
    run(1); #2;
    check("post_rst_req", 32'(imem_req), 32'd1);
    check("post_rst_addr", imem_addr, RESET_PC);
    check("post_rst_occ", 32'(occupancy), 32'd0);
    // Randomized traffic.
    p_ack = 60; p_ready = 60; p_redir = 5; p_rst = 5; p_spur = 15; p_owed = 50;
    run(3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, at least 2.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port startin  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port imem_req  output  1  instruction-memory request valid.
REQ-006 SHALL have port imem_addr  output  32  request word address.
REQ-007 SHALL have port imem_ack  input  1  memory returns data this cycle.
REQ-008 SHALL have port imem_rdata  input  32  returned instruction, valid with imem_ack.
REQ-009 SHALL have port redirect  input  1  branch taken, flush and refetch.
REQ-010 SHALL have port redirect_pc  input  32  new fetch address.
REQ-011 SHALL have port id_ready  input  1  decode stage accepts head entry.
REQ-012 SHALL have port id_valid  output  1  head entry present.
REQ-013 SHALL have port id_instr  output  32  head instruction; 0 when id_valid=0.
REQ-014 SHALL have port id_pc_plus_4  output  32  head entry fetch address + 4; 0 when id_valid=0.
REQ-015 SHALL have port occupancy  output  $clog2(DEPTH)+1  stored entries.

Function
REQ-016 SHALL run FSM IDLE, REQ, DROP; at most one memory request outstanding.
REQ-017 In IDLE, with no redirect, SHALL enter REQ when occupancy < DEPTH (reserves one slot).
REQ-018 In REQ, SHALL assert imem_req=1 and hold imem_addr=fetch_pc stable until imem_ack.
REQ-019 In REQ, on imem_ack without redirect, SHALL push {imem_rdata, fetch_pc+4} and set fetch_pc += 4 (mod 2^32).
REQ-020 In REQ, on imem_ack, SHALL stay in REQ if post-update occupancy < DEPTH, else go IDLE.
REQ-021 SHALL pop the head entry on id_valid && id_ready; push and pop in the same cycle leave occupancy unchanged.
REQ-022 Read/write pointers SHALL wrap modulo DEPTH; a push while full SHALL not occur (REQ-017 guarantees it).
REQ-023 On redirect, SHALL in one cycle: empty the FIFO, set fetch_pc = {redirect_pc[31:2],2'b00}, and block pop and push.
REQ-024 Redirect in REQ without imem_ack SHALL go to DROP; redirect with imem_ack same cycle SHALL discard the data and go IDLE.
REQ-025 In DROP, SHALL deassert imem_req, discard data on imem_ack, then go IDLE; a further redirect SHALL update fetch_pc and stay in DROP.
REQ-026 imem_ack in IDLE SHALL be ignored.
REQ-027 Without bypass, ack in cycle N SHALL give id_valid=1 in cycle N+1.

Reset
REQ-028 startin=1 at a clock edge SHALL set state IDLE, fetch_pc=RESET_PC, FIFO empty, pointers 0, occupancy 0.
REQ-029 During and after reset, SHALL hold imem_req=0, id_valid=0, id_instr=0, id_pc_plus_4=0, occupancy=0.
REQ-030 Reset mid-request SHALL abandon the request; a stale imem_ack after reset falls under REQ-026.

Configuration
REQ-031 With macro FETCH_QUEUE_BYPASS_EN defined, FIFO empty, and imem_ack in REQ without redirect, SHALL drive that data on id_instr/id_pc_plus_4 with id_valid=1 in the same cycle.
REQ-032 Under REQ-031, with id_ready=1 the entry SHALL be consumed without being stored, otherwise it SHALL be stored.
REQ-033 Without FETCH_QUEUE_BYPASS_EN, SHALL have no combinational path from imem_* to id_*; latency is REQ-027.

Verification
REQ-034 Reset, ack 1 cycle after each request, id_ready=1 -> addrs 0,4,8,...; id_pc_plus_4 4,8,12 in order; id_valid one cycle after each ack.
REQ-035 id_ready=0, DEPTH=4, immediate acks -> occupancy reaches 4, imem_req drops, no fifth request.
REQ-036 id_ready=1 with FIFO full -> pop frees slot, occupancy 3, imem_req reasserts with next address.
REQ-037 Redirect to 32'h0000_0103 while request at 8 is unacked, ack arrives 2 cycles later -> data discarded; next imem_addr=32'h0000_0100; occupancy 0.
REQ-038 Redirect and imem_ack same cycle -> ack data not seen on id_*; next request at redirect target.
REQ-039 startin pulse with occupancy 3 and a request outstanding -> all outputs 0, stale ack ignored, next imem_addr=RESET_PC.
